st2_branch_ctrl: RTL
====================

ST2_BRANCH_CTRL -- requirements
Module: st2_branch_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of branch target.
REQ-002 SHALL have parameter MAX_WAIT, default 4, cycles allowed in WAIT_OPND before abort.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port br_valid  in  1  stage-2 branch present; held by pipeline while stall=1.
REQ-006 SHALL have port br_type  in  2  00 BEQ, 01 BGT, 10 BLT, 11 reserved.
REQ-007 SHALL have port br_target  in  DATA_W  taken-branch PC.
REQ-008 SHALL have port op_ready  in  1  forwarding reports op1/reg15 valid at comparator inputs.
REQ-009 SHALL have port cmp_result  in  2  comparator output: 00 equal, 01 op1>reg15, 10 op1<reg15, 11 invalid.
REQ-010 SHALL have port stall  out  1  freeze IF/ID.
REQ-011 SHALL have port flush  out  1  squash IF/ID instruction.
REQ-012 SHALL have port pc_sel  out  1  1 = load pc_target into PC.
REQ-013 SHALL have port pc_target  out  DATA_W  latched br_target.
REQ-014 SHALL have port err  out  1  sticky: timeout or cmp_result=11 seen in RESOLVE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_OPND, RESOLVE, FLUSH.
REQ-016 IDLE: br_valid&op_ready -> RESOLVE; br_valid&!op_ready -> WAIT_OPND; both latch br_type, br_target.
REQ-017 WAIT_OPND: op_ready -> RESOLVE; else wait counter increments; counter reaching MAX_WAIT -> IDLE, err=1, no redirect.
REQ-018 RESOLVE: taken = (BEQ&cmp=00)|(BGT&cmp=01)|(BLT&cmp=10); taken -> FLUSH, else -> IDLE.
REQ-019 br_type=11 or cmp_result=11 SHALL resolve not-taken; cmp_result=11 sets err.
REQ-020 FLUSH: pc_sel=1, flush=1, pc_target=latched value for exactly one cycle, then IDLE.
REQ-021 stall SHALL be combinational: (IDLE&br_valid) | WAIT_OPND | RESOLVE; 0 in FLUSH.
REQ-022 Latency: br_valid with op_ready in cycle N -> RESOLVE N+1 -> pc_sel/flush in N+2.
REQ-023 br_valid outside IDLE SHALL be ignored; new branch accepted in the cycle FSM returns to IDLE.
REQ-024 pc_sel, flush SHALL be 0 in all states except FLUSH.

Reset
REQ-025 rst SHALL force IDLE, wait counter 0, latches 0, pc_target 0, err 0 on the next edge, including mid-WAIT_OPND/RESOLVE/FLUSH.
REQ-026 While rst=1, stall, flush, pc_sel SHALL be 0.

Configuration
REQ-027 Macro BRANCH_STATS_EN defined: adds outputs br_cnt[15:0] (branches resolved) and taken_cnt[15:0] (entries to FLUSH), saturating at FFFF, cleared by rst.
REQ-028 BRANCH_STATS_EN undefined: counters and ports absent; all other behaviour identical.

Structure
REQ-029 Package st2_pkg SHALL hold br_type encodings, cmp_result encodings, FSM state enum.
REQ-030 Taken decision SHALL be sub-module st2_branch_eval (combinational: br_type, cmp_result -> taken, invalid).
REQ-031 Comparator stays external; controller consumes only cmp_result.

Verification
REQ-032 BEQ, op_ready=1, cmp=00, target=0x0040 -> stall 1 cycle in IDLE + RESOLVE; pc_sel=flush=1, pc_target=0x0040 in N+2.
REQ-033 BGT, cmp=10 -> RESOLVE then IDLE; pc_sel never asserted; stall low from N+2.
REQ-034 BLT, op_ready=0 for 2 cycles then 1, cmp=10 -> WAIT_OPND 2 cycles, RESOLVE, FLUSH; stall continuous until FLUSH.
REQ-035 op_ready held 0, MAX_WAIT=4 -> after 4 WAIT_OPND cycles IDLE, err=1, no pc_sel.
REQ-036 rst pulsed in RESOLVE with taken condition -> no FLUSH; all outputs 0 next cycle.
REQ-037 BRANCH_STATS_EN: 3 taken + 2 not-taken branches -> br_cnt=5, taken_cnt=3.

Source files
------------

// File: rtl/st2_pkg.sv
// ---------------------------------------------------------------------------
// st2_pkg
// Shared definitions for the stage-2 branch controller:
//   - br_type encodings (BEQ / BGT / BLT / reserved)
//   - cmp_result encodings from the external comparator
//   - controller FSM state enum
//   - width of the optional statistics counters and a saturating increment
// ---------------------------------------------------------------------------
package st2_pkg;

    // Branch condition encodings carried with the stage-2 instruction.
    typedef enum logic [1:0] {
        BR_BEQ  = 2'b00,
        BR_BGT  = 2'b01,
        BR_BLT  = 2'b10,
        BR_RSVD = 2'b11
    } br_type_e;

    // Comparator verdict for op1 versus reg15.
    typedef enum logic [1:0] {
        CMP_EQ  = 2'b00,
        CMP_GT  = 2'b01,
        CMP_LT  = 2'b10,
        CMP_INV = 2'b11
    } cmp_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_OPND = 2'b01,
        ST_RESOLVE   = 2'b10,
        ST_FLUSH     = 2'b11
    } st2_state_e;

    // Width of the optional branch statistics counters.
    localparam int STAT_W = 16;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        logic [STAT_W-1:0] result;
        if (value == {STAT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage : st2_pkg

// File: rtl/st2_branch_eval.sv
// ---------------------------------------------------------------------------
// st2_branch_eval
// Purely combinational taken/not-taken decision for a stage-2 branch.
//
// Ports:
//   br_type    in  [1:0]  branch condition (BEQ/BGT/BLT/reserved)
//   cmp_result in  [1:0]  comparator verdict (EQ/GT/LT/invalid)
//   taken      out        branch condition satisfied
//   invalid    out        comparator reported an invalid result
//
// A reserved br_type or an invalid cmp_result never produces taken.
// ---------------------------------------------------------------------------
module st2_branch_eval
    import st2_pkg::*;
(
    input  logic [1:0] br_type,
    input  logic [1:0] cmp_result,
    output logic       taken,
    output logic       invalid
);

    logic taken_s;
    logic invalid_s;

    // Match branch condition against comparator verdict.
    always_comb begin
        taken_s   = 1'b0;
        invalid_s = (cmp_result == CMP_INV);
        case (br_type)
            BR_BEQ:  taken_s = (cmp_result == CMP_EQ);
            BR_BGT:  taken_s = (cmp_result == CMP_GT);
            BR_BLT:  taken_s = (cmp_result == CMP_LT);
            default: taken_s = 1'b0;
        endcase
    end

    assign taken   = taken_s;
    assign invalid = invalid_s;

endmodule : st2_branch_eval

// File: rtl/st2_branch_ctrl.sv
// ---------------------------------------------------------------------------
// st2_branch_ctrl
// Stage-2 branch controller. Accepts a branch from the pipeline, waits for
// forwarded operands if needed, resolves taken/not-taken from the external
// comparator result and, when taken, redirects the PC and squashes IF/ID for
// one cycle.
//
// Parameters:
//   DATA_W    width of the branch target / PC
//   MAX_WAIT  cycles allowed in WAIT_OPND before the branch is abandoned
//
// Ports:
//   clk        in               rising-edge clock
//   rst        in               synchronous active-high reset
//   br_valid   in               stage-2 branch present
//   br_type    in  [1:0]        branch condition
//   br_target  in  [DATA_W-1:0] taken-branch PC
//   op_ready   in               comparator operands valid
//   cmp_result in  [1:0]        comparator verdict
//   stall      out              freeze IF/ID (combinational)
//   flush      out              squash IF/ID instruction
//   pc_sel     out              load pc_target into PC
//   pc_target  out [DATA_W-1:0] latched branch target
//   err        out              sticky: operand timeout or invalid compare
//   br_cnt     out [15:0]       branches resolved      (BRANCH_STATS_EN only)
//   taken_cnt  out [15:0]       taken branches         (BRANCH_STATS_EN only)
//
// Configuration macro: BRANCH_STATS_EN adds the saturating statistics
// counters and their output ports.
// ---------------------------------------------------------------------------
module st2_branch_ctrl
    import st2_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic [DATA_W-1:0] br_target,
    input  logic              op_ready,
    input  logic [1:0]        cmp_result,
    output logic              stall,
    output logic              flush,
    output logic              pc_sel,
    output logic [DATA_W-1:0] pc_target,
    output logic              err
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] taken_cnt
`endif
);

    // Wide enough to hold MAX_WAIT itself.
    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    st2_state_e        state_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0]  wait_cnt_d;
    logic [1:0]        type_q;
    logic [DATA_W-1:0] target_q;
    logic              err_q;

    logic              taken_s;
    logic              invalid_s;
    logic              timeout_s;
    logic              stall_s;
    logic              redirect_s;

    // Decision logic operates on the latched branch type so that the
    // pipeline is free to change br_type once the branch is accepted.
    st2_branch_eval u_eval (
        .br_type    (type_q),
        .cmp_result (cmp_result),
        .taken      (taken_s),
        .invalid    (invalid_s)
    );

    // Next wait count and the abandon condition for WAIT_OPND.
    always_comb begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        timeout_s  = (wait_cnt_d == CNT_W'(MAX_WAIT));
    end

    // Controller FSM with its latched branch fields and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= {CNT_W{1'b0}};
            type_q     <= 2'b00;
            target_q   <= {DATA_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (br_valid) begin
                        type_q     <= br_type;
                        target_q   <= br_target;
                        wait_cnt_q <= {CNT_W{1'b0}};
                        state_q    <= op_ready ? ST_RESOLVE : ST_WAIT_OPND;
                    end
                end
                ST_WAIT_OPND: begin
                    if (op_ready) begin
                        state_q <= ST_RESOLVE;
                    end else if (timeout_s) begin
                        // Operands never arrived: drop the branch, no redirect.
                        state_q    <= ST_IDLE;
                        err_q      <= 1'b1;
                        wait_cnt_q <= {CNT_W{1'b0}};
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                ST_RESOLVE: begin
                    if (invalid_s) begin
                        err_q <= 1'b1;
                    end
                    state_q <= taken_s ? ST_FLUSH : ST_IDLE;
                end
                ST_FLUSH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall and redirect decode; both forced low while reset is asserted.
    always_comb begin
        stall_s    = 1'b0;
        redirect_s = 1'b0;
        if (rst) begin
            stall_s    = 1'b0;
            redirect_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:      stall_s    = br_valid;
                ST_WAIT_OPND: stall_s    = 1'b1;
                ST_RESOLVE:   stall_s    = 1'b1;
                ST_FLUSH:     redirect_s = 1'b1;
                default: begin
                    stall_s    = 1'b0;
                    redirect_s = 1'b0;
                end
            endcase
        end
    end

    assign stall     = stall_s;
    assign flush     = redirect_s;
    assign pc_sel    = redirect_s;
    assign pc_target = target_q;
    assign err       = err_q;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] br_cnt_q;
    logic [STAT_W-1:0] taken_cnt_q;

    // Count every resolution and every resolution that leads to FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q    <= {STAT_W{1'b0}};
            taken_cnt_q <= {STAT_W{1'b0}};
        end else if (state_q == ST_RESOLVE) begin
            br_cnt_q <= sat_inc(br_cnt_q);
            if (taken_s) begin
                taken_cnt_q <= sat_inc(taken_cnt_q);
            end
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;
`endif

endmodule : st2_branch_ctrl
